// File: rtl/muldiv_pkg.sv
// Shared MulDiv definitions: default operand width and the divider state encoding.
package muldiv_pkg;

  localparam int N = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int N = 4
) (
  input  logic [N:0]   prem,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N:0]   prem_next,
  output logic         q_bit
);

  logic [N:0] shifted;
  logic [N:0] dvs_ext;

  assign shifted = {prem[N-1:0], bit_in};
  assign dvs_ext = {1'b0, divisor};

  // A set MSB means the shifted value already exceeds any N-bit divisor.
  assign q_bit     = prem[N] | (shifted >= dvs_ext);
  assign prem_next = q_bit ? shifted - dvs_ext : shifted;

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
module seq_div
  import muldiv_pkg::*;
#(
  parameter int N = muldiv_pkg::N
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CW = $clog2(2*N) + 1;

  div_state_t state, state_next;

  logic [CW-1:0]  cnt;
  logic [2*N-1:0] dvd_q;   // dividend bits leave at the MSB, quotient bits enter at the LSB
  logic [N-1:0]   dvs_q;
  logic [N:0]     prem_q;
  logic [N:0]     prem_next;
  logic           q_bit;
  logic           accept;
  logic           last;

  div_step #(.N(N)) u_step (
    .prem      (prem_q),
    .bit_in    (dvd_q[2*N-1]),
    .divisor   (dvs_q),
    .prem_next (prem_next),
    .q_bit     (q_bit)
  );

  assign accept = ready & start;
  assign last   = (cnt == CW'(2*N-1));

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = (divisor == '0) ? DONE : RUN;
      end
      RUN:  if (last) state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        dvd_q  <= dividend;
        dvs_q  <= divisor;
        prem_q <= '0;
        cnt    <= '0;
        // Zero divisor skips RUN; the result is published on the accepting edge.
        if (divisor == '0) begin
          quotient    <= '1;
          remainder   <= dividend[N-1:0];
          div_by_zero <= 1'b1;
        end
      end else if (state == RUN) begin
        prem_q <= prem_next;
        dvd_q  <= {dvd_q[2*N-2:0], q_bit};
        cnt    <= cnt + 1'b1;
        if (last) begin
          quotient    <= {dvd_q[2*N-2:0], q_bit};
          remainder   <= prem_next[N-1:0];
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: arithmetic reference model with per-cycle compare, plus directed literal vectors.
module tb_seq_div;
  import muldiv_pkg::*;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [2*N-1:0] dividend = '0;
  logic [N-1:0]   divisor = '0;
  logic           ready, done, div_by_zero;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;

  int checks = 0;
  int errors = 0;

  seq_div #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: a division takes 2N cycles after acceptance (none for a zero divisor),
  // results come from / and %, and the published values hold until the next completion.
  bit             live = 1'b0;
  int             busy = 0;
  bit             m_done = 1'b0;
  bit             m_rdy;
  logic [2*N-1:0] m_q = '0, p_q = '0;
  logic [N-1:0]   m_r = '0, p_r = '0;
  logic           m_z = 1'b0, p_z = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      live = 1'b1; busy = 0; m_done = 1'b0;
      m_q = '0; m_r = '0; m_z = 1'b0;
    end else if (live) begin
      m_rdy  = (busy == 0) && !m_done;
      m_done = 1'b0;
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          m_done = 1'b1; m_q = p_q; m_r = p_r; m_z = p_z;
        end
      end
      if (m_rdy && start) begin
        if (divisor == '0) begin
          m_q = '1; m_r = dividend[N-1:0]; m_z = 1'b1; m_done = 1'b1;
        end else begin
          p_q  = dividend / (2*N)'(divisor);
          p_r  = N'(dividend % (2*N)'(divisor));
          p_z  = 1'b0;
          busy = 2*N;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("cmp_ready", 32'(ready), 32'(busy == 0 && !m_done));
      chk("cmp_done",  32'(done),  32'(m_done));
      chk("cmp_quot",  32'(quotient),    32'(m_q));
      chk("cmp_rem",   32'(remainder),   32'(m_r));
      chk("cmp_dbz",   32'(div_by_zero), 32'(m_z));
    end
  end

  task automatic issue(input logic [2*N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    chk("ready_before_start", 32'(ready), 32'd1);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = (2*N)'($urandom);
    divisor  = N'($urandom);
  endtask

  // Counts cycles after the accepting edge until done; optionally pokes start mid-run.
  task automatic wait_res(input string nm, input logic [2*N-1:0] eq, input logic [N-1:0] er,
                          input logic ez, input int elat, input bit poke);
    int n = 0;
    bit got = 0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) got = 1;
      if (poke && n == 2) begin start = 1'b1; dividend = 8'd16; divisor = 4'd2; end
      if (poke && n == 5) start = 1'b0;
    end
    chk({nm, "_latency"}, 32'(n), 32'(elat));
    chk({nm, "_quot"}, 32'(quotient), 32'(eq));
    chk({nm, "_rem"},  32'(remainder), 32'(er));
    chk({nm, "_dbz"},  32'(div_by_zero), 32'(ez));
    @(negedge clk);
    chk({nm, "_ready_after"}, 32'(ready), 32'd1);
    chk({nm, "_done_pulse"},  32'(done),  32'd0);
  endtask

  initial begin
    int dcount;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_quot",  32'(quotient), 32'd0);
    chk("rst_rem",   32'(remainder), 32'd0);
    chk("rst_dbz",   32'(div_by_zero), 32'd0);
    reset = 1'b0;

    issue(8'd225, 4'd15); wait_res("d225_15", 8'd15,  4'd0, 1'b0, 9, 1'b0);
    issue(8'd0,   4'd1);  wait_res("d0_1",    8'd0,   4'd0, 1'b0, 9, 1'b0);
    issue(8'd255, 4'd1);  wait_res("d255_1",  8'd255, 4'd0, 1'b0, 9, 1'b0);
    issue(8'd200, 4'd7);  wait_res("d200_7",  8'd28,  4'd4, 1'b0, 9, 1'b0);
    repeat (5) @(negedge clk);
    chk("hold_quot", 32'(quotient), 32'd28);
    chk("hold_rem",  32'(remainder), 32'd4);
    issue(8'd100, 4'd0);  wait_res("d100_0",  8'd255, 4'd4, 1'b1, 1, 1'b0);
    issue(8'd100, 4'd10); wait_res("d100_10", 8'd10,  4'd0, 1'b0, 9, 1'b0);

    // Abort a division three cycles into RUN.
    issue(8'd200, 4'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_quot",  32'(quotient), 32'd0);
    chk("abort_rem",   32'(remainder), 32'd0);
    chk("abort_dbz",   32'(div_by_zero), 32'd0);
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0) dcount++;
    end
    chk("abort_no_done", 32'(dcount), 32'd0);

    // start during RUN must not disturb the running division.
    issue(8'd225, 4'd15); wait_res("ignore_start", 8'd15, 4'd0, 1'b0, 9, 1'b1);

    // Back-to-back with start held: one result every 2N+2 cycles.
    @(negedge clk);
    start = 1'b1; dividend = 8'd77; divisor = 4'd5;
    repeat (25) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("b2b_quot", 32'(quotient), 32'd15);
    chk("b2b_rem",  32'(remainder), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

endmodule
